tmds_channel_rx: RTL



---
 rtl/tmds_channel_rx_pkg.sv | 20 ++
 rtl/tmds_decode_word.sv | 36 +++
 rtl/tmds_channel_rx.sv | 138 +++++++++++++
 3 files changed

// File: rtl/tmds_channel_rx_pkg.sv
// Shared definitions for the TMDS receive channel: control-token codes and
// alignment FSM state encodings.
package tmds_channel_rx_pkg;

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;  // c0=1, c1=0
  localparam logic [9:0] TOK_C10 = 10'b0101010100;  // c0=0, c1=1
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } rx_state_t;

  function automatic logic [3:0] next_offset(input logic [3:0] off);
    return (off == 4'd9) ? 4'd0 : off + 4'd1;
  endfunction

endpackage

// File: rtl/tmds_decode_word.sv
// Combinational TMDS word decoder: flags control tokens (with their c1/c0 code)
// and undoes the transition-minimising 8b/10b data encoding.
module tmds_decode_word
  import tmds_channel_rx_pkg::*;
(
  input  logic [9:0] q,
  output logic       is_token,
  output logic [1:0] c,
  output logic [7:0] d
);

  logic [7:0] t;

  always_comb begin
    is_token = 1'b1;
    c        = 2'b00;
    case (q)
      TOK_C00: c = 2'b00;
      TOK_C01: c = 2'b01;
      TOK_C10: c = 2'b10;
      TOK_C11: c = 2'b11;
      default: is_token = 1'b0;
    endcase
  end

  // q[9] marks an inverted payload, q[8] selects XOR versus XNOR chaining.
  always_comb begin
    t    = q[9] ? ~q[7:0] : q[7:0];
    d    = 8'h00;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = q[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
  end

endmodule

// File: rtl/tmds_channel_rx.sv
// One TMDS receive channel: finds the 10-bit word boundary by hunting for
// control tokens, then registers decoded data or control bits.
//
// state  | meaning
// SEARCH | hunting for any control token at the current bit offset
// VERIFY | counting consecutive identical tokens before declaring lock
// LOCKED | aligned; decoding words and watching for token starvation
module tmds_channel_rx
  import tmds_channel_rx_pkg::*;
#(
  parameter int SEARCH_CYCLES = 2048,
  parameter int LOCK_TOKENS   = 8,
  parameter int LOSS_CYCLES   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_in,
  input  logic       realign,
  output logic [7:0] d_out,
  output logic       c0,
  output logic       c1,
  output logic       de_out,
  output logic       locked,
  output logic [3:0] bit_offset
);

  localparam int CYC_W = $clog2(SEARCH_CYCLES);
  localparam int TOK_W = $clog2(LOCK_TOKENS);
  localparam int GAP_W = $clog2(LOSS_CYCLES);

  rx_state_t        state;
  logic [9:0]       raw_r;
  logic [9:0]       raw_rr;
  logic [9:0]       aligned;
  logic [CYC_W-1:0] cyc_cnt;
  logic [TOK_W-1:0] tok_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [1:0]       ref_tok;
  logic             is_token;
  logic [1:0]       tok_c;
  logic [7:0]       dec_d;

  // raw_rr holds the older word, so the window reads earliest bit first from bit 0.
  assign aligned = 10'({raw_r, raw_rr} >> bit_offset);

  tmds_decode_word u_decode (
    .q        (aligned),
    .is_token (is_token),
    .c        (tok_c),
    .d        (dec_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SEARCH;
      raw_r      <= '0;
      raw_rr     <= '0;
      cyc_cnt    <= '0;
      tok_cnt    <= '0;
      gap_cnt    <= '0;
      ref_tok    <= '0;
      bit_offset <= '0;
      locked     <= 1'b0;
      d_out      <= '0;
      c0         <= 1'b0;
      c1         <= 1'b0;
      de_out     <= 1'b0;
    end else begin
      raw_r  <= raw_in;
      raw_rr <= raw_r;

      if (state == LOCKED && is_token) begin
        de_out <= 1'b0;
        d_out  <= '0;
        c0     <= tok_c[0];
        c1     <= tok_c[1];
      end else if (state == LOCKED) begin
        de_out <= 1'b1;
        d_out  <= dec_d;
      end else begin
        de_out <= 1'b0;
        d_out  <= '0;
      end

      if (realign) begin
        state   <= SEARCH;
        locked  <= 1'b0;
        cyc_cnt <= '0;
      end else begin
        case (state)
          SEARCH: begin
            if (is_token) begin
              state   <= VERIFY;
              tok_cnt <= TOK_W'(1);
              ref_tok <= tok_c;
            end else if (cyc_cnt == CYC_W'(SEARCH_CYCLES - 1)) begin
              cyc_cnt    <= '0;
              bit_offset <= next_offset(bit_offset);
            end else begin
              cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
          end
          VERIFY: begin
            if (!is_token) begin
              state   <= SEARCH;
              cyc_cnt <= '0;
            end else if (tok_c != ref_tok) begin
              tok_cnt <= TOK_W'(1);
              ref_tok <= tok_c;
            end else if (tok_cnt == TOK_W'(LOCK_TOKENS - 1)) begin
              state   <= LOCKED;
              locked  <= 1'b1;
              gap_cnt <= '0;
            end else begin
              tok_cnt <= tok_cnt + TOK_W'(1);
            end
          end
          LOCKED: begin
            if (is_token) begin
              gap_cnt <= '0;
            end else if (gap_cnt == GAP_W'(LOSS_CYCLES - 1)) begin
              state   <= SEARCH;
              locked  <= 1'b0;
              cyc_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
          default: begin
            state  <= SEARCH;
            locked <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
